// File: rtl/pong_engine.sv
// Purpose : Pong game engine - match FSM, ball/paddle kinematics, scoring, serve delay, game-over hold.
// Latency : every update is registered; start/ack/tick effects are visible one clk after they are sampled.
// Backpressure: none; the renderer reads the registered coordinates and the engine never stalls.
// Ports   : clk/reset (async active-high), tick frame strobe, start/ack match control, four player
//           buttons in; ball_x/ball_y, paddle tops, scores, state, game_over and winner out (all registered).
module pong_engine #(
    parameter int COORD_W     = 10,
    parameter int SCORE_W     = 4,
    parameter int FIELD_W     = 640,
    parameter int FIELD_H     = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_X_L  = 16,
    parameter int PADDLE_X_R  = 616,
    parameter int BALL_STEP   = 2,
    parameter int PADDLE_STEP = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               ack,
    input  logic               left_up,
    input  logic               left_down,
    input  logic               right_up,
    input  logic               right_down,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] left_paddle_y,
    output logic [COORD_W-1:0] right_paddle_y,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic [1:0]         state,
    output logic               game_over,
    output logic               winner
);

    // Comparisons run one bit wider than the coordinates so sums never wrap.
    localparam int W     = COORD_W + 1;
    localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;

    localparam logic [COORD_W-1:0] BX0    = COORD_W'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] BY0    = COORD_W'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] PY0    = COORD_W'((FIELD_H - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0] XL_N   = COORD_W'(PADDLE_X_L + PADDLE_W);
    localparam logic [COORD_W-1:0] XR_N   = COORD_W'(PADDLE_X_R - BALL_SIZE);
    localparam logic [COORD_W-1:0] PMAX_N = COORD_W'(FIELD_H - PADDLE_H);
    localparam logic [COORD_W-1:0] BYMX_N = COORD_W'(FIELD_H - BALL_SIZE);
    localparam logic [COORD_W-1:0] BST_N  = COORD_W'(BALL_STEP);
    localparam logic [COORD_W-1:0] PST_N  = COORD_W'(PADDLE_STEP);

    localparam logic [W-1:0] XL_W   = W'(PADDLE_X_L + PADDLE_W);
    localparam logic [W-1:0] XR_W   = W'(PADDLE_X_R - BALL_SIZE);
    localparam logic [W-1:0] PMAX_W = W'(FIELD_H - PADDLE_H);
    localparam logic [W-1:0] BYMX_W = W'(FIELD_H - BALL_SIZE);
    localparam logic [W-1:0] BST_W  = W'(BALL_STEP);
    localparam logic [W-1:0] PST_W  = W'(PADDLE_STEP);
    localparam logic [W-1:0] BSZ_W  = W'(BALL_SIZE);
    localparam logic [W-1:0] PH_W   = W'(PADDLE_H);

    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SRV_LAST = CNT_W'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    state_t               st_q, st_n;
    logic [COORD_W-1:0]   bx_q, bx_n, by_q, by_n, lp_q, lp_n, rp_q, rp_n;
    logic [SCORE_W-1:0]   ls_q, ls_n, rs_q, rs_n;
    logic                 dx_q, dx_n, dy_q, dy_n;
    logic                 win_q, win_n, over_q, over_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 left_hit, right_hit;
    logic [SCORE_W-1:0]   ls_inc, rs_inc;

    function automatic logic [COORD_W-1:0] move_paddle(input logic [COORD_W-1:0] y,
                                                       input logic up, input logic dn);
        logic [W-1:0] yw;
        yw = {1'b0, y};
        move_paddle = y;
        if (up && !dn) begin
            move_paddle = (yw <= PST_W) ? '0 : y - PST_N;
        end else if (dn && !up) begin
            move_paddle = (yw + PST_W >= PMAX_W) ? PMAX_N : y + PST_N;
        end
    endfunction

    // Overlap uses the paddle positions from before this tick's paddle move.
    assign left_hit  = ({1'b0, by_q} + BSZ_W > {1'b0, lp_q}) && ({1'b0, by_q} < {1'b0, lp_q} + PH_W);
    assign right_hit = ({1'b0, by_q} + BSZ_W > {1'b0, rp_q}) && ({1'b0, by_q} < {1'b0, rp_q} + PH_W);
    assign ls_inc    = ls_q + 1'b1;
    assign rs_inc    = rs_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            bx_q   <= BX0;
            by_q   <= BY0;
            lp_q   <= PY0;
            rp_q   <= PY0;
            ls_q   <= '0;
            rs_q   <= '0;
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            win_q  <= 1'b0;
            over_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_n;
            bx_q   <= bx_n;
            by_q   <= by_n;
            lp_q   <= lp_n;
            rp_q   <= rp_n;
            ls_q   <= ls_n;
            rs_q   <= rs_n;
            dx_q   <= dx_n;
            dy_q   <= dy_n;
            win_q  <= win_n;
            over_q <= over_n;
            cnt_q  <= cnt_n;
        end
    end

    always_comb begin
        st_n   = st_q;
        bx_n   = bx_q;
        by_n   = by_q;
        lp_n   = lp_q;
        rp_n   = rp_q;
        ls_n   = ls_q;
        rs_n   = rs_q;
        dx_n   = dx_q;
        dy_n   = dy_q;
        win_n  = win_q;
        over_n = over_q;
        cnt_n  = cnt_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_n  = SERVE;
                    cnt_n = '0;
                end
            end
            SERVE: begin
                if (tick) begin
                    lp_n = move_paddle(lp_q, left_up, left_down);
                    rp_n = move_paddle(rp_q, right_up, right_down);
                    if (cnt_q == SRV_LAST) begin
                        st_n = PLAY;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    lp_n = move_paddle(lp_q, left_up, left_down);
                    rp_n = move_paddle(rp_q, right_up, right_down);
                    // Vertical and horizontal resolve independently so corners flip both bits.
                    if (!dy_q && ({1'b0, by_q} <= BST_W)) begin
                        by_n = '0;
                        dy_n = 1'b1;
                    end else if (dy_q && ({1'b0, by_q} + BST_W >= BYMX_W)) begin
                        by_n = BYMX_N;
                        dy_n = 1'b0;
                    end else begin
                        by_n = dy_q ? by_q + BST_N : by_q - BST_N;
                    end
                    if (!dx_q && ({1'b0, bx_q} <= XL_W + BST_W)) begin
                        if (left_hit) begin
                            bx_n = XL_N;
                            dx_n = 1'b1;
                        end else begin
                            // Right player scores; the ball re-serves toward the left.
                            rs_n  = rs_inc;
                            bx_n  = BX0;
                            by_n  = BY0;
                            dx_n  = 1'b0;
                            dy_n  = dy_q;
                            cnt_n = '0;
                            if (rs_inc == WIN_S) begin
                                st_n   = OVER;
                                win_n  = 1'b1;
                                over_n = 1'b1;
                            end else begin
                                st_n = SERVE;
                            end
                        end
                    end else if (dx_q && ({1'b0, bx_q} + BST_W >= XR_W)) begin
                        if (right_hit) begin
                            bx_n = XR_N;
                            dx_n = 1'b0;
                        end else begin
                            ls_n  = ls_inc;
                            bx_n  = BX0;
                            by_n  = BY0;
                            dx_n  = 1'b1;
                            dy_n  = dy_q;
                            cnt_n = '0;
                            if (ls_inc == WIN_S) begin
                                st_n   = OVER;
                                win_n  = 1'b0;
                                over_n = 1'b1;
                            end else begin
                                st_n = SERVE;
                            end
                        end
                    end else begin
                        bx_n = dx_q ? bx_q + BST_N : bx_q - BST_N;
                    end
                end
            end
            OVER: begin
                if (ack) begin
                    st_n   = IDLE;
                    bx_n   = BX0;
                    by_n   = BY0;
                    lp_n   = PY0;
                    rp_n   = PY0;
                    ls_n   = '0;
                    rs_n   = '0;
                    dx_n   = 1'b1;
                    dy_n   = 1'b1;
                    win_n  = 1'b0;
                    over_n = 1'b0;
                    cnt_n  = '0;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    assign ball_x         = bx_q;
    assign ball_y         = by_q;
    assign left_paddle_y  = lp_q;
    assign right_paddle_y = rp_q;
    assign left_score     = ls_q;
    assign right_score    = rs_q;
    assign state          = st_q;
    assign game_over      = over_q;
    assign winner         = win_q;

endmodule

// File: tb/tb_pong_engine.sv
// Purpose : directed bench for pong_engine; stimulus queues expected outputs, a monitor compares them.
// Latency : expectations are queued just after the clk edge that should produce them, checked on the next falling edge.
// Backpressure: not applicable; every run length is a fixed tick count so the bench always ends.
module tb_pong_engine;

    logic       clk = 1'b0;
    logic       reset, tick, start, ack;
    logic       left_up, left_down, right_up, right_down;
    logic [9:0] ball_x, ball_y, left_paddle_y, right_paddle_y;
    logic [3:0] left_score, right_score;
    logic [1:0] state;
    logic       game_over, winner;

    pong_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .ack(ack),
        .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
        .ball_x(ball_x), .ball_y(ball_y), .left_paddle_y(left_paddle_y),
        .right_paddle_y(right_paddle_y), .left_score(left_score), .right_score(right_score),
        .state(state), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    localparam int S_BX = 0, S_BY = 1, S_LP = 2, S_RP = 3, S_LS = 4, S_RS = 5,
                   S_ST = 6, S_GO = 7, S_WN = 8;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_act;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int sample(input int sel);
        case (sel)
            S_BX:    return int'(ball_x);
            S_BY:    return int'(ball_y);
            S_LP:    return int'(left_paddle_y);
            S_RP:    return int'(right_paddle_y);
            S_LS:    return int'(left_score);
            S_RS:    return int'(right_score);
            S_ST:    return int'(state);
            S_GO:    return int'(game_over);
            default: return int'(winner);
        endcase
    endfunction

    // Monitor: outputs are stable at the falling edge; drain everything queued since the last one.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = sample(mon_e.sel);
            n_checks++;
            if (mon_act != mon_e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic push(input string nm, input int sel, input int v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_ball(input string nm, input int x, input int y);
        push({nm, " ball_x"}, S_BX, x);
        push({nm, " ball_y"}, S_BY, y);
    endtask

    task automatic push_idle(input string nm);
        push_ball(nm, 316, 236);
        push({nm, " left_paddle_y"}, S_LP, 208);
        push({nm, " right_paddle_y"}, S_RP, 208);
        push({nm, " left_score"}, S_LS, 0);
        push({nm, " right_score"}, S_RS, 0);
        push({nm, " state"}, S_ST, 0);
        push({nm, " game_over"}, S_GO, 0);
        push({nm, " winner"}, S_WN, 0);
    endtask

    // Each tick is one high cycle followed by one low cycle; returns just after the edge that used it.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk); #1 tick = 1'b1;
            @(posedge clk); #1 tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; ack = 1'b0;
        left_up = 1'b0; left_down = 1'b0; right_up = 1'b0; right_down = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push_idle("reset");

        // IDLE ignores ticks and buttons.
        left_up = 1'b1;
        tick_n(2);
        push("idle state", S_ST, 0);
        push("idle left_paddle_y", S_LP, 208);
        left_up = 1'b0;

        // ---------------- Match 1: left player wins 7-0 ----------------
        pulse_start();
        push("start state", S_ST, 1);
        push_ball("start", 316, 236);

        left_up = 1'b1; left_down = 1'b1; right_up = 1'b1;
        tick_n(2);
        push("both pressed left_paddle_y", S_LP, 208);
        push("serve right_paddle_y", S_RP, 200);
        left_down = 1'b0;
        tick_n(1);
        push("left_up 1 tick", S_LP, 204);
        tick_n(26);
        push("tick 29 state", S_ST, 1);
        push("tick 29 left_paddle_y", S_LP, 100);
        push_ball("serve hold", 316, 236);
        tick_n(1);
        push("tick 30 state", S_ST, 2);
        push("tick 30 left_paddle_y", S_LP, 96);
        push_ball("tick 30", 316, 236);
        tick_n(1);
        push_ball("first play tick", 318, 238);
        tick_n(22);
        push("left paddle near top", S_LP, 4);
        tick_n(1);
        push("left paddle at top", S_LP, 0);
        tick_n(8);
        push("left paddle clamped", S_LP, 0);
        push("right paddle clamped", S_RP, 0);
        push_ball("play 32", 380, 300);
        left_up = 1'b0;
        tick_n(113);
        push_ball("pre-miss", 606, 418);
        push("pre-miss left_score", S_LS, 0);
        push("pre-miss state", S_ST, 2);
        tick_n(1);
        push("miss left_score", S_LS, 1);
        push("miss right_score", S_RS, 0);
        push("miss state", S_ST, 1);
        push_ball("miss recentre", 316, 236);

        // Point 2: ball now serves right and upward; the right paddle sits at the bottom.
        right_up = 1'b0; right_down = 1'b1;
        tick_n(31);
        push("point2 state", S_ST, 2);
        push_ball("point2 first play", 318, 234);
        tick_n(145);
        push("point2 left_score", S_LS, 2);
        push("point2 state", S_ST, 1);

        for (int p = 3; p <= 7; p++) begin
            right_up   = (p % 2 == 1);
            right_down = (p % 2 == 0);
            tick_n(175);
            push("pre-point left_score", S_LS, p - 1);
            push("pre-point state", S_ST, 2);
            tick_n(1);
            push("point left_score", S_LS, p);
            push("point state", S_ST, (p == 7) ? 3 : 1);
        end
        push("win game_over", S_GO, 1);
        push("win winner", S_WN, 0);
        push("win right_score", S_RS, 0);
        push_ball("win", 316, 236);

        // OVER freezes everything, including start.
        right_up = 1'b0; left_down = 1'b1; right_down = 1'b1; start = 1'b1;
        tick_n(5);
        start = 1'b0;
        push("over state", S_ST, 3);
        push("over left_paddle_y", S_LP, 0);
        push("over right_paddle_y", S_RP, 0);
        push("over left_score", S_LS, 7);
        push_ball("over", 316, 236);

        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        push_idle("ack");
        left_down = 1'b0; right_down = 1'b0;

        // ---------------- Match 2: paddle hits and wall bounces ----------------
        pulse_start();
        left_up = 1'b1; right_down = 1'b1;
        tick_n(10);
        push("m2 left_paddle_y", S_LP, 168);
        push("m2 right_paddle_y", S_RP, 248);
        left_up = 1'b0;
        tick_n(20);
        push("m2 play state", S_ST, 2);
        tick_n(117);
        push_ball("m2 near bottom", 550, 470);
        tick_n(1);
        push_ball("m2 bottom wall", 552, 472);
        tick_n(1);
        push_ball("m2 after bottom", 554, 470);
        tick_n(26);
        push_ball("m2 pre right hit", 606, 418);
        tick_n(1);
        push_ball("m2 right hit", 608, 416);
        push("m2 right hit left_score", S_LS, 0);
        push("m2 right hit state", S_ST, 2);
        tick_n(207);
        push_ball("m2 near top", 194, 2);
        tick_n(1);
        push_ball("m2 top wall", 192, 0);
        tick_n(1);
        push_ball("m2 after top", 190, 2);
        tick_n(82);
        push_ball("m2 pre left hit", 26, 166);
        tick_n(1);
        push_ball("m2 left hit", 24, 168);
        push("m2 left hit right_score", S_RS, 0);
        push("m2 left hit left_score", S_LS, 0);
        tick_n(1);
        push_ball("m2 after left hit", 26, 170);

        // Asynchronous reset mid-play, observed while still asserted.
        @(posedge clk); #2 reset = 1'b1;
        #1 push_idle("mid reset");
        @(negedge clk); #1 reset = 1'b0;
        right_down = 1'b0;
        tick_n(3);
        push("post reset state", S_ST, 0);
        pulse_start();
        push("restart state", S_ST, 1);

        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
